// File: rtl/debug_pkg.sv
// Shared DMI register map, abstract-command field positions and state/error
// encodings for the debug module core.
package debug_pkg;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DATA1      = 7'h05;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam int unsigned DMC_HALTREQ   = 31;
    localparam int unsigned DMC_RESUMEREQ = 30;
    localparam int unsigned DMC_NDMRESET  = 1;
    localparam int unsigned DMC_DMACTIVE  = 0;

    localparam int unsigned ACS_BUSY       = 12;
    localparam int unsigned ACS_CMDERR_LSB = 8;

    localparam int unsigned CMD_TYPE_MSB    = 31;
    localparam int unsigned CMD_TYPE_LSB    = 24;
    localparam int unsigned CMD_AARSIZE_MSB = 22;
    localparam int unsigned CMD_AARSIZE_LSB = 20;
    localparam int unsigned CMD_POSTEXEC    = 18;
    localparam int unsigned CMD_TRANSFER    = 17;
    localparam int unsigned CMD_WRITE       = 16;
    localparam logic [2:0]  AARSIZE_32      = 3'd2;

    localparam logic [3:0] DMSTATUS_VERSION = 4'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_t;

    typedef enum logic [2:0] {
        ABS_IDLE  = 3'd0,
        ABS_CHECK = 3'd1,
        ABS_REQ   = 3'd2,
        ABS_WAIT  = 3'd3,
        ABS_DONE  = 3'd4
    } abs_state_t;

endpackage

// File: rtl/debug_dm_abstract_fsm.sv
// Abstract-command sequencer: validates a latched Access Register command,
// drives the hart register-access port and owns the sticky cmderr field.
module debug_dm_abstract_fsm
    import debug_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        cmd_we_i,
    input  logic [7:0]  cmd_type_i,
    input  logic [2:0]  cmd_aarsize_i,
    input  logic        cmd_postexec_i,
    input  logic        cmd_transfer_i,
    input  logic        cmd_write_i,
    input  logic [15:0] cmd_regno_i,
    input  logic [31:0] data0_i,
    input  logic [2:0]  cmderr_w1c_i,
    input  logic        busy_err_i,
    input  logic        halted_i,
    output logic        busy_o,
    output cmderr_t     cmderr_o,
    output logic        data0_we_o,
    output logic        ar_req_o,
    output logic        ar_wr_o,
    output logic [15:0] ar_addr_o,
    output logic [31:0] ar_wdata_o,
    input  logic        ar_ack_i,
    input  logic        ar_err_i
);

    abs_state_t  state_q;
    cmderr_t     cmderr_q;
    cmderr_t     err_d;
    logic        bad_q;
    logic        transfer_q;
    logic        write_q;
    logic [15:0] regno_q;
    logic        ar_req_q;
    logic        ar_wr_q;
    logic [15:0] ar_addr_q;
    logic [31:0] ar_wdata_q;
    logic        in_flight;

    // An ack is accepted in REQ as well as WAIT so a fast hart is never missed.
    assign in_flight  = (state_q == ABS_REQ) || (state_q == ABS_WAIT);
    assign busy_o     = (state_q != ABS_IDLE);
    assign cmderr_o   = cmderr_q;
    assign data0_we_o = in_flight && ar_ack_i && !ar_err_i && !ar_wr_q;
    assign ar_req_o   = ar_req_q;
    assign ar_wr_o    = ar_wr_q;
    assign ar_addr_o  = ar_addr_q;
    assign ar_wdata_o = ar_wdata_q;

    always_comb begin
        err_d = CMDERR_NONE;
        if (state_q == ABS_CHECK) begin
            if (bad_q)
                err_d = CMDERR_NOTSUP;
            else if (transfer_q && !halted_i)
                err_d = CMDERR_HALTRESUME;
        end else if (in_flight && ar_ack_i && ar_err_i) begin
            err_d = CMDERR_EXCEPT;
        end
        if (err_d == CMDERR_NONE && busy_err_i)
            err_d = CMDERR_BUSY;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= ABS_IDLE;
            cmderr_q   <= CMDERR_NONE;
            bad_q      <= 1'b0;
            transfer_q <= 1'b0;
            write_q    <= 1'b0;
            regno_q    <= '0;
            ar_req_q   <= 1'b0;
            ar_wr_q    <= 1'b0;
            ar_addr_q  <= '0;
            ar_wdata_q <= '0;
        end else begin
            if (cmderr_q == CMDERR_NONE)
                cmderr_q <= err_d;
            else
                cmderr_q <= cmderr_t'(cmderr_q & ~cmderr_w1c_i);

            case (state_q)
                ABS_IDLE: begin
                    if (cmd_we_i && cmderr_q == CMDERR_NONE) begin
                        bad_q      <= (cmd_type_i != '0) || cmd_postexec_i ||
                                      (cmd_aarsize_i != AARSIZE_32);
                        transfer_q <= cmd_transfer_i;
                        write_q    <= cmd_write_i;
                        regno_q    <= cmd_regno_i;
                        state_q    <= ABS_CHECK;
                    end
                end
                ABS_CHECK: begin
                    if (bad_q || (transfer_q && !halted_i)) begin
                        state_q <= ABS_IDLE;
                    end else if (!transfer_q) begin
                        state_q <= ABS_DONE;
                    end else begin
                        ar_req_q   <= 1'b1;
                        ar_wr_q    <= write_q;
                        ar_addr_q  <= regno_q;
                        ar_wdata_q <= data0_i;
                        state_q    <= ABS_REQ;
                    end
                end
                ABS_REQ, ABS_WAIT: begin
                    if (ar_ack_i) begin
                        ar_req_q <= 1'b0;
                        state_q  <= ABS_DONE;
                    end else begin
                        state_q  <= ABS_WAIT;
                    end
                end
                ABS_DONE: state_q <= ABS_IDLE;
                default:  state_q <= ABS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_dm_core.sv
// RISC-V Debug Module core: DMI register decode, dmcontrol/dmstatus handling
// and the abstract-command engine feeding the hart register-access port.
module debug_dm_core
    import debug_pkg::*;
#(
    parameter int unsigned ABITS     = 7,
    parameter int unsigned DATACOUNT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DMI_WR,
    input  logic             DMI_RD,
    input  logic [ABITS-1:0] DMI_AD,
    input  logic [31:0]      DMI_DI,
    output logic [31:0]      DMI_DO,
    output logic             DMI_DO_VLD,
    output logic             NDMRESET,
    output logic             HALTREQ,
    output logic             RESUMEREQ,
    input  logic             HALTED,
    input  logic             RUNNING,
    output logic             AR_REQ,
    output logic             AR_WR,
    output logic [15:0]      AR_ADDR,
    output logic [31:0]      AR_WDATA,
    input  logic             AR_ACK,
    input  logic [31:0]      AR_RDATA,
    input  logic             AR_ERR
);

    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        resumereq_q, resumereq_d;
    logic        resumeack_q, resumeack_d;
    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] do_q;
    logic        do_vld_q;
    logic [31:0] rdata;

    logic        sel_data0, sel_data1, sel_dmc, sel_acs, sel_cmd;
    logic        dmc_wr, reg_wr_ok, dm_clr, busy, busy_err, data0_we;
    logic [2:0]  cmderr_w1c;
    cmderr_t     cmderr;
    logic [31:0] dmcontrol, dmstatus, abstractcs;

    assign sel_data0 = (DMI_AD == ABITS'(ADDR_DATA0));
    assign sel_data1 = (DMI_AD == ABITS'(ADDR_DATA1));
    assign sel_dmc   = (DMI_AD == ABITS'(ADDR_DMCONTROL));
    assign sel_acs   = (DMI_AD == ABITS'(ADDR_ABSTRACTCS));
    assign sel_cmd   = (DMI_AD == ABITS'(ADDR_COMMAND));

    assign dmc_wr    = DMI_WR && sel_dmc && dmactive_q;
    assign reg_wr_ok = dmactive_q && !busy;
    assign busy_err  = busy && ((DMI_WR && (sel_data0 || sel_data1 || sel_acs || sel_cmd)) ||
                                (DMI_RD && (sel_data0 || sel_data1)));
    assign cmderr_w1c = (DMI_WR && sel_acs && reg_wr_ok) ?
                        DMI_DI[ACS_CMDERR_LSB +: 3] : '0;

    // Clearing keys off the next dmactive so deactivation takes effect on the write edge.
    assign dm_clr = RST || !dmactive_d;

    always_comb begin
        dmactive_d  = (DMI_WR && sel_dmc) ? DMI_DI[DMC_DMACTIVE] : dmactive_q;
        haltreq_d   = haltreq_q;
        ndmreset_d  = ndmreset_q;
        resumereq_d = resumereq_q;
        resumeack_d = resumeack_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        if (dmc_wr) begin
            haltreq_d  = DMI_DI[DMC_HALTREQ];
            ndmreset_d = DMI_DI[DMC_NDMRESET];
        end
        if (resumereq_q && RUNNING) begin
            resumereq_d = 1'b0;
            resumeack_d = 1'b1;
        end
        if (dmc_wr && DMI_DI[DMC_RESUMEREQ] && !DMI_DI[DMC_HALTREQ]) begin
            resumereq_d = 1'b1;
            resumeack_d = 1'b0;
        end
        if (data0_we)
            data0_d = AR_RDATA;
        else if (DMI_WR && sel_data0 && reg_wr_ok)
            data0_d = DMI_DI;
        if (DMI_WR && sel_data1 && reg_wr_ok)
            data1_d = DMI_DI;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            dmactive_q <= 1'b0;
        else
            dmactive_q <= dmactive_d;

        if (dm_clr) begin
            haltreq_q   <= 1'b0;
            ndmreset_q  <= 1'b0;
            resumereq_q <= 1'b0;
            resumeack_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            haltreq_q   <= haltreq_d;
            ndmreset_q  <= ndmreset_d;
            resumereq_q <= resumereq_d;
            resumeack_q <= resumeack_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    assign dmcontrol  = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
    assign dmstatus   = {14'b0, resumeack_q, resumeack_q, 4'b0, RUNNING, RUNNING,
                         HALTED, HALTED, 1'b1, 3'b0, DMSTATUS_VERSION};
    assign abstractcs = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'(DATACOUNT)};

    always_comb begin
        rdata = '0;
        case (DMI_AD)
            ABITS'(ADDR_DATA0):      rdata = data0_q;
            ABITS'(ADDR_DATA1):      rdata = data1_q;
            ABITS'(ADDR_DMCONTROL):  rdata = dmcontrol;
            ABITS'(ADDR_DMSTATUS):   rdata = dmstatus;
            ABITS'(ADDR_ABSTRACTCS): rdata = abstractcs;
            default:                 rdata = '0;
        endcase
    end

    // Reads use pre-edge state, so a same-cycle write is not visible to the read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            do_q     <= '0;
            do_vld_q <= 1'b0;
        end else begin
            do_vld_q <= DMI_RD;
            if (DMI_RD)
                do_q <= rdata;
        end
    end

    debug_dm_abstract_fsm u_abs (
        .clk_i          (CLK),
        .clr_i          (dm_clr),
        .cmd_we_i       (DMI_WR && sel_cmd && dmactive_q),
        .cmd_type_i     (DMI_DI[CMD_TYPE_MSB:CMD_TYPE_LSB]),
        .cmd_aarsize_i  (DMI_DI[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB]),
        .cmd_postexec_i (DMI_DI[CMD_POSTEXEC]),
        .cmd_transfer_i (DMI_DI[CMD_TRANSFER]),
        .cmd_write_i    (DMI_DI[CMD_WRITE]),
        .cmd_regno_i    (DMI_DI[15:0]),
        .data0_i        (data0_q),
        .cmderr_w1c_i   (cmderr_w1c),
        .busy_err_i     (busy_err),
        .halted_i       (HALTED),
        .busy_o         (busy),
        .cmderr_o       (cmderr),
        .data0_we_o     (data0_we),
        .ar_req_o       (AR_REQ),
        .ar_wr_o        (AR_WR),
        .ar_addr_o      (AR_ADDR),
        .ar_wdata_o     (AR_WDATA),
        .ar_ack_i       (AR_ACK),
        .ar_err_i       (AR_ERR)
    );

    assign DMI_DO     = do_q;
    assign DMI_DO_VLD = do_vld_q;
    assign NDMRESET   = ndmreset_q;
    assign HALTREQ    = haltreq_q;
    assign RESUMEREQ  = resumereq_q;

endmodule
